pseudo_softmax_ctrl: RTL and testbench



---
 rtl/pseudo_softmax_pkg.sv | 16 +
 rtl/pseudo_softmax_ctrl_lse_step.sv | 29 ++
 rtl/pseudo_softmax_ctrl.sv | 110 +++++++++++
 tb/tb_pseudo_softmax_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_softmax_pkg.sv
// Shared constants and FSM state type for the pseudo-softmax frame sequencer.
package pseudo_softmax_pkg;
    localparam int N       = 10;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 9;
    localparam int IDX_W   = $clog2(N);
    localparam int SAT_MAX = (1 << OUT_W) - 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        LOAD,
        CAPTURE,
        EMIT
    } state_e;
endpackage

// File: rtl/pseudo_softmax_ctrl_lse_step.sv
// One step of the approximate log-sum-exp: max(s,x) plus 1 when the operands are within 1.
// Purely combinational, saturates at 2^OUT_W-1.
module lse_step
    import pseudo_softmax_pkg::*;
(
    input  logic [OUT_W-1:0] s_i,
    input  logic [IN_W-1:0]  x_i,
    output logic [OUT_W-1:0] y_o
);
    logic [OUT_W:0] s_w;
    logic [OUT_W:0] x_w;
    logic [OUT_W:0] m_w;
    logic [OUT_W:0] d_w;
    logic [OUT_W:0] r_w;

    always_comb begin
        s_w = {1'b0, s_i};
        x_w = (OUT_W+1)'(x_i);
        if (s_w >= x_w) begin
            m_w = s_w;
            d_w = s_w - x_w;
        end else begin
            m_w = x_w;
            d_w = x_w - s_w;
        end
        r_w = m_w + {{OUT_W{1'b0}}, (d_w <= (OUT_W+1)'(1))};
        y_o = (r_w > (OUT_W+1)'(SAT_MAX)) ? OUT_W'(SAT_MAX) : r_w[OUT_W-1:0];
    end
endmodule

// File: rtl/pseudo_softmax_ctrl.sv
// Loads N scores, feeds exp_sum/scores to the external subtractor array, streams N results (last accept -> out_valid in 2 cycles).
// out_ready low freezes the result beat; no input is taken until the frame drains. Optional SOFTMAX_ARGMAX_EN adds out_argmax.
module pseudo_softmax_ctrl
    import pseudo_softmax_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_last,
    output logic [OUT_W-1:0]     sub_exp_sum,
    output logic [N*IN_W-1:0]    sub_x,
    input  logic [N*OUT_W-1:0]   sub_exp_out
`ifdef SOFTMAX_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]     out_argmax
`endif
);
    state_e                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            k_q;
    logic [OUT_W-1:0]            sum_q;
    logic [OUT_W-1:0]            sum_d;
    logic [OUT_W-1:0]            lse_y;
    logic [N-1:0][IN_W-1:0]      slot_q;
    logic [N-1:0][OUT_W-1:0]     buf_q;
`ifdef SOFTMAX_ARGMAX_EN
    logic [IN_W-1:0]             max_q;
    logic [IDX_W-1:0]            amax_q;
`endif

    lse_step u_lse (
        .s_i (sum_q),
        .x_i (in_data),
        .y_o (lse_y)
    );

    // The first score of a frame seeds the running sum instead of folding into stale state.
    always_comb begin
        sum_d = (idx_q == '0) ? OUT_W'(in_data) : lse_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            k_q     <= '0;
            sum_q   <= '0;
            slot_q  <= '0;
            buf_q   <= '0;
`ifdef SOFTMAX_ARGMAX_EN
            max_q   <= '0;
            amax_q  <= '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        slot_q[idx_q] <= in_data;
                        sum_q         <= sum_d;
`ifdef SOFTMAX_ARGMAX_EN
                        if ((idx_q == '0) || (in_data > max_q)) begin
                            max_q  <= in_data;
                            amax_q <= idx_q;
                        end
`endif
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= CAPTURE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    buf_q   <= sub_exp_out;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (k_q == LAST_IDX) begin
                            k_q     <= '0;
                            state_q <= LOAD;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state_q == LOAD) && !rst;
        out_valid   = (state_q == EMIT);
        out_data    = (state_q == EMIT) ? buf_q[k_q] : '0;
        out_last    = (state_q == EMIT) && (k_q == LAST_IDX);
        sub_exp_sum = sum_q;
        sub_x       = slot_q;
    end

`ifdef SOFTMAX_ARGMAX_EN
    assign out_argmax = amax_q;
`endif
endmodule

// File: tb/tb_pseudo_softmax_ctrl.sv
// Frame-level bench: table of score frames with expected exp_sum/results, plus a mid-frame reset sequence.
module tb_pseudo_softmax_ctrl;
    import pseudo_softmax_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic                 out_last;
    logic [OUT_W-1:0]     sub_exp_sum;
    logic [N*IN_W-1:0]    sub_x;
    logic [N*OUT_W-1:0]   sub_exp_out;
`ifdef SOFTMAX_ARGMAX_EN
    logic [IDX_W-1:0]     out_argmax;
`endif

    always #5 clk = ~clk;

    pseudo_softmax_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .sub_exp_sum (sub_exp_sum),
        .sub_x       (sub_x),
        .sub_exp_out (sub_exp_out)
`ifdef SOFTMAX_ARGMAX_EN
        ,
        .out_argmax  (out_argmax)
`endif
    );

    // Stand-in for the sibling subtractor array: exp_out_i = exp_sum - x_i.
    for (genvar g = 0; g < N; g++) begin : g_sub
        assign sub_exp_out[g*OUT_W +: OUT_W] = sub_exp_sum - OUT_W'(sub_x[g*IN_W +: IN_W]);
    end

    typedef struct packed {
        logic [N-1:0][IN_W-1:0]  x;
        logic [OUT_W-1:0]        esum;
        logic [N-1:0][OUT_W-1:0] res;
        logic [IDX_W-1:0]        amax;
        logic                    gap;
        int                      bp;
    } vec_t;

    int n_pass = 0;
    int n_chk  = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mkv(input int xs[N], input int es, input int rs[N],
                                 input int am, input logic gap, input int bp);
        vec_t v;
        for (int i = 0; i < N; i++) begin
            v.x[i]   = IN_W'(xs[i]);
            v.res[i] = OUT_W'(rs[i]);
        end
        v.esum = OUT_W'(es);
        v.amax = IDX_W'(am);
        v.gap  = gap;
        v.bp   = bp;
        return v;
    endfunction

    // Reference: fold the scores with max-plus-correction on plain integers.
    function automatic vec_t model(input int xs[N], input logic gap, input int bp);
        int s, best, d;
        int rs[N];
        s    = xs[0];
        best = 0;
        for (int i = 1; i < N; i++) begin
            d = (s > xs[i]) ? s - xs[i] : xs[i] - s;
            s = ((s > xs[i]) ? s : xs[i]) + ((d <= 1) ? 1 : 0);
            if (s > SAT_MAX) s = SAT_MAX;
            if (xs[i] > xs[best]) best = i;
        end
        for (int i = 0; i < N; i++) rs[i] = s - xs[i];
        return mkv(xs, s, rs, best, gap, bp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // abort_beat >= 0 asserts reset while that result beat is presented.
    task automatic run_frame(input vec_t v, input int abort_beat);
        int cnt;
        for (int i = 0; i < N; i++) begin
            if (v.gap) begin
                in_valid = 1'b0;
                tick();
                tick();
            end
            in_valid = 1'b1;
            in_data  = v.x[i];
            cnt = 0;
            while (!in_ready && cnt < 50) begin
                tick();
                cnt++;
            end
            if (cnt >= 50) chk("in_ready_timeout", 0, 1);
            tick();
        end
        in_valid = 1'b0;
        chk("capture_in_ready", int'(in_ready), 0);
        chk("capture_out_valid", int'(out_valid), 0);
        chk("exp_sum", int'(sub_exp_sum), int'(v.esum));
        for (int i = 0; i < N; i++) chk("sub_x", int'(sub_x[i*IN_W +: IN_W]), int'(v.x[i]));
        tick();
        chk("latency_out_valid", int'(out_valid), 1);
        for (int k = 0; k < N; k++) begin
            if (k == abort_beat) begin
                rst = 1'b1;
                tick();
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_exp_sum", int'(sub_exp_sum), 0);
                chk("rst_in_ready", int'(in_ready), 0);
                chk("rst_out_data", int'(out_data), 0);
                rst = 1'b0;
                #1;
                chk("post_rst_in_ready", int'(in_ready), 1);
                return;
            end
            if (k == v.bp) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    tick();
                    chk("bp_out_valid", int'(out_valid), 1);
                    chk("bp_hold_data", int'(out_data), int'(v.res[k]));
                end
                out_ready = 1'b1;
            end
            chk("beat_valid", int'(out_valid), 1);
            chk("beat_data", int'(out_data), int'(v.res[k]));
            chk("beat_last", int'(out_last), (k == N - 1) ? 1 : 0);
            chk("emit_in_ready", int'(in_ready), 0);
`ifdef SOFTMAX_ARGMAX_EN
            chk("argmax", int'(out_argmax), int'(v.amax));
`endif
            tick();
        end
        chk("done_in_ready", int'(in_ready), 1);
        chk("done_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        int t[N];
        int r[N];
        int base;
        vec_t eq100;

        for (int i = 0; i < N; i++) begin
            t[i] = 100;
            r[i] = 2;
        end
        eq100 = mkv(t, 102, r, 0, 1'b0, -1);
        vecs.push_back(eq100);
        t = '{100, 75, 25, 37, 62, 87, 112, 125, 50, 45};
        r = '{25, 50, 100, 88, 63, 38, 13, 0, 75, 80};
        vecs.push_back(mkv(t, 125, r, 7, 1'b0, 2));
        vecs.push_back(mkv(t, 125, r, 7, 1'b1, -1));
        t = '{9, 200, 200, 0, 0, 0, 0, 0, 0, 0};
        r = '{192, 1, 1, 201, 201, 201, 201, 201, 201, 201};
        vecs.push_back(mkv(t, 201, r, 1, 1'b0, -1));
        for (int j = 0; j < 8; j++) begin
            base = $urandom_range(0, 252);
            for (int i = 0; i < N; i++)
                t[i] = (j % 2 == 0) ? base + $urandom_range(0, 3) : $urandom_range(0, 255);
            vecs.push_back(model(t, 1'($urandom_range(0, 1)), $urandom_range(0, 10) - 1));
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_last", int'(out_last), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_exp_sum", int'(sub_exp_sum), 0);
        chk("reset_sub_x_zero", int'(sub_x == '0), 1);
`ifdef SOFTMAX_ARGMAX_EN
        chk("reset_argmax", int'(out_argmax), 0);
`endif
        rst = 1'b0;
        #1;
        chk("release_in_ready", int'(in_ready), 1);

        foreach (vecs[i]) run_frame(vecs[i], -1);

        run_frame(eq100, 3);
        run_frame(eq100, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks so far %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
